// File: rtl/ha_array_accum_if.sv
// ha_array_accum_if: handshake bundle between the ha_array row producer,
// the ha_array_accum final adder and its consumer.
//   in_valid/in_ready          : upstream handshake
//   ha_array_{0..3}_b (7b)     : carry rows of the four row groups
//   ha_array_{0..3}_t (9b)     : sum rows of the four row groups
//   out_valid/out_ready        : downstream handshake
//   product (OUT_W), ovf       : reduced product and overflow flag
// The master modport is the side that supplies rows and consumes the product.
// The slave modport is the adder stage.
interface ha_array_accum_if #(
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       ha_array_0_b;
  logic [8:0]       ha_array_0_t;
  logic [6:0]       ha_array_1_b;
  logic [8:0]       ha_array_1_t;
  logic [6:0]       ha_array_2_b;
  logic [8:0]       ha_array_2_t;
  logic [6:0]       ha_array_3_b;
  logic [8:0]       ha_array_3_t;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] product;
  logic             ovf;

  modport master (
    output in_valid, ha_array_0_b, ha_array_0_t, ha_array_1_b, ha_array_1_t,
           ha_array_2_b, ha_array_2_t, ha_array_3_b, ha_array_3_t, out_ready,
    input  in_ready, out_valid, product, ovf
  );

  modport slave (
    input  in_valid, ha_array_0_b, ha_array_0_t, ha_array_1_b, ha_array_1_t,
           ha_array_2_b, ha_array_2_t, ha_array_3_b, ha_array_3_t, out_ready,
    output in_ready, out_valid, product, ovf
  );
endinterface

// File: rtl/ha_array_accum.sv
// ha_array_accum: two-stage pipelined final adder for the 8x8 unsigned
// ha_array partial-product generator.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears both stages and outputs
//   bus    : ha_array_accum_if slave side (row groups in, product/ovf out)
// Each group G_i = t_i + (b_i << 2); the exact product is
// G0 + (G1<<2) + (G2<<4) + (G3<<6). Stage 1 forms the two partial sums
// P0 = G0 + (G1<<2) and P1 = G2 + (G3<<2); stage 2 forms P0 + (P1<<4),
// flags overflow above 2^OUT_W-1 and optionally saturates.
module ha_array_accum #(
  parameter int OUT_W  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  ha_array_accum_if.slave bus
);

  // Wide enough for the exact 17-bit sum and for the overflow test at OUT_W.
  localparam int SUM_W = (OUT_W >= 17) ? OUT_W + 1 : 17;

  function automatic logic [9:0] grp(input logic [6:0] b, input logic [8:0] t);
    return {1'b0, t} + {1'b0, b, 2'b00};
  endfunction

  logic             s1_valid_reg;
  logic [12:0]      p0_reg;
  logic [12:0]      p1_reg;
  logic             s2_valid_reg;
  logic [OUT_W-1:0] product_reg;
  logic             ovf_reg;

  logic             s1_adv;
  logic             s2_adv;
  logic [9:0]       g0, g1, g2, g3;
  logic [12:0]      p0_next;
  logic [12:0]      p1_next;
  logic [SUM_W-1:0] sum_wide;
  logic             ovf_next;
  logic [OUT_W-1:0] product_next;

  // Backpressure chain: stage 2 moves when empty or drained, stage 1 when
  // empty or stage 2 is moving. in_ready therefore depends on out_ready
  // combinationally, but nothing feeds in_valid through to out_valid.
  assign s2_adv = !s2_valid_reg || bus.out_ready;
  assign s1_adv = !s1_valid_reg || s2_adv;

  always_comb begin
    g0       = grp(bus.ha_array_0_b, bus.ha_array_0_t);
    g1       = grp(bus.ha_array_1_b, bus.ha_array_1_t);
    g2       = grp(bus.ha_array_2_b, bus.ha_array_2_t);
    g3       = grp(bus.ha_array_3_b, bus.ha_array_3_t);
    p0_next  = 13'(g0) + (13'(g1) << 2);
    p1_next  = 13'(g2) + (13'(g3) << 2);
    sum_wide = SUM_W'(p0_reg) + (SUM_W'(p1_reg) << 4);
    // Anything at or above bit OUT_W means the sum left the output range;
    // only approximate (out-of-range) row encodings can get there.
    ovf_next = |(sum_wide >> OUT_W);
    if (SAT_EN && ovf_next) begin
      product_next = '1;
    end else begin
      product_next = sum_wide[OUT_W-1:0];
    end
  end

  // Stage 1: data only captured when a valid input is actually accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      p0_reg       <= '0;
      p1_reg       <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        p0_reg <= p0_next;
        p1_reg <= p1_next;
      end
    end
  end

  // Stage 2: product/ovf hold while stalled, so the consumer sees stable data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      product_reg  <= '0;
      ovf_reg      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        product_reg <= product_next;
        ovf_reg     <= ovf_next;
      end
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_reg;
  assign bus.product   = product_reg;
  assign bus.ovf       = ovf_reg;

endmodule
